sr_cmd_gen: RTL and testbench

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

---
 rtl/sr_cmd_pkg.sv | 23 ++
 rtl/sr_debounce.sv | 59 +++++
 rtl/sr_cmd_gen.sv | 162 ++++++++++++++++
 tb/tb_sr_cmd_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared types, default parameters and helpers for the SR command
// generator (sr_cmd_gen and its sr_debounce input conditioners).
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_LOCKOUT = 2'd2
  } sr_state_t;

  localparam int unsigned DEB_CYCLES_DEF     = 32'd16;
  localparam int unsigned LOCKOUT_CYCLES_DEF = 32'd4;

  // Saturating 8-bit increment used by the conflict statistics counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: 2-flop synchronizer, stability-count debouncer and rising-edge
// detector for one raw asynchronous input. The rise output is a registered
// one-cycle pulse issued on the same edge the debounced level goes high.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 32'd1);

  logic        sync1_r;
  logic        sync2_r;
  logic        deb_r;
  logic        rise_r;
  logic [15:0] cnt_r;

  // Two-stage synchronizer for the raw asynchronous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive disagreeing samples; flip the level on the last one and
  // flag a rising edge in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= 16'd0;
      deb_r  <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      if (sync2_r != deb_r) begin
        if (cnt_r == CNT_LAST) begin
          deb_r  <= ~deb_r;
          cnt_r  <= 16'd0;
          rise_r <= ~deb_r;
        end else begin
          cnt_r <= cnt_r + 16'd1;
        end
      end else begin
        cnt_r <= 16'd0;
      end
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns debounced set/clear presses into one-cycle s/r commands
// for a downstream SR flip-flop, with clear-wins conflict handling and a
// post-command lockout. Define SR_CMD_STATS_EN to add the saturating
// conflict_cnt output.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_in,
  input  logic       clr_in,
  output logic       s,
  output logic       r,
  output logic       busy,
`ifdef SR_CMD_STATS_EN
  output logic       conflict,
  output logic [7:0] conflict_cnt
`else
  output logic       conflict
`endif
);

  localparam logic       LOCK_EN   = (LOCKOUT_CYCLES != 32'd0);
  localparam logic [7:0] LOCK_LAST = LOCK_EN ? 8'(LOCKOUT_CYCLES - 32'd1) : 8'd0;

  logic      set_pulse_s;
  logic      clr_pulse_s;
  sr_state_t state_r;
  sr_state_t state_nxt_s;
  logic [7:0] lock_cnt_r;
  logic [7:0] lock_cnt_nxt_s;
  logic      s_nxt_s;
  logic      r_nxt_s;
  logic      conflict_nxt_s;
  logic      busy_nxt_s;
  logic      s_r;
  logic      r_r;
  logic      conflict_r;
  logic      busy_r;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk  (clk),
    .rst  (rst),
    .raw  (set_in),
    .rise (set_pulse_s)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk  (clk),
    .rst  (rst),
    .raw  (clr_in),
    .rise (clr_pulse_s)
  );

  // FSM state and lockout counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      lock_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
    end
  end

  // Next-state logic; requests outside IDLE are simply ignored.
  always_comb begin
    state_nxt_s    = state_r;
    lock_cnt_nxt_s = lock_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (set_pulse_s || clr_pulse_s) begin
          state_nxt_s    = ST_ISSUE;
          lock_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        lock_cnt_nxt_s = 8'd0;
        if (LOCK_EN) begin
          state_nxt_s = ST_LOCKOUT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_r == LOCK_LAST) begin
          state_nxt_s    = ST_IDLE;
          lock_cnt_nxt_s = 8'd0;
        end else begin
          lock_cnt_nxt_s = lock_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        lock_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Output decode: clear wins a simultaneous request and flags the conflict.
  always_comb begin
    s_nxt_s        = 1'b0;
    r_nxt_s        = 1'b0;
    conflict_nxt_s = 1'b0;
    busy_nxt_s     = (state_nxt_s != ST_IDLE);
    if (state_r == ST_IDLE) begin
      if (clr_pulse_s) begin
        r_nxt_s        = 1'b1;
        conflict_nxt_s = set_pulse_s;
      end else if (set_pulse_s) begin
        s_nxt_s = 1'b1;
      end else begin
        s_nxt_s = 1'b0;
      end
    end else begin
      s_nxt_s = 1'b0;
    end
  end

  // Registered command, conflict and busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r        <= 1'b0;
      r_r        <= 1'b0;
      conflict_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      s_r        <= s_nxt_s;
      r_r        <= r_nxt_s;
      conflict_r <= conflict_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign s        = s_r;
  assign r        = r_r;
  assign conflict = conflict_r;
  assign busy     = busy_r;

`ifdef SR_CMD_STATS_EN
  logic [7:0] conflict_cnt_r;

  // Saturating count of conflict pulses, updated with the conflict output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_r <= 8'd0;
    end else if (conflict_nxt_s) begin
      conflict_cnt_r <= sat_inc8(conflict_cnt_r);
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed self-checking bench for sr_cmd_gen with
// DEB_CYCLES=4, LOCKOUT_CYCLES=4. Inputs change 1 ns after a rising edge, so
// "edge k" of a window is the k-th rising edge after the stimulus change.
module tb_sr_cmd_gen;

  localparam int unsigned DEB  = 32'd4;
  localparam int unsigned LOCK = 32'd4;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic set_in = 1'b0;
  logic clr_in = 1'b0;
  logic s;
  logic r;
  logic busy;
  logic conflict;
`ifdef SR_CMD_STATS_EN
  logic [7:0] conflict_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sr_cmd_gen #(.DEB_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_in       (set_in),
    .clr_in       (clr_in),
    .s            (s),
    .r            (r),
    .busy         (busy),
`ifdef SR_CMD_STATS_EN
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
`else
    .conflict     (conflict)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Step ncyc edges checking s/r/busy/conflict against the expected schedule.
  // s_at/r_at: edge after which the pulse is high (0 = never); busy high for
  // edges b_lo..b_hi; conflict expected with r when conf is set; clr_in is
  // raised after edge clr_at (0 = never).
  task automatic window(input string tag, input int ncyc, input int s_at, input int r_at,
                        input int b_lo, input int b_hi, input bit conf, input int clr_at);
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      chk($sformatf("%s_s@%0d", tag, k), {7'd0, s}, (k == s_at) ? 8'd1 : 8'd0);
      chk($sformatf("%s_r@%0d", tag, k), {7'd0, r}, (k == r_at) ? 8'd1 : 8'd0);
      chk($sformatf("%s_busy@%0d", tag, k), {7'd0, busy},
          (k >= b_lo && k <= b_hi) ? 8'd1 : 8'd0);
      chk($sformatf("%s_conf@%0d", tag, k), {7'd0, conflict},
          (conf && k == r_at) ? 8'd1 : 8'd0);
      if (k == clr_at) clr_in = 1'b1;
    end
  endtask

  initial begin
    // Reset held with a request active: everything stays quiet.
    set_in = 1'b1;
    repeat (10) tick();
    chk("rst_s", {7'd0, s}, 8'd0);
    chk("rst_r", {7'd0, r}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_conf", {7'd0, conflict}, 8'd0);
`ifdef SR_CMD_STATS_EN
    chk("rst_cnt", conflict_cnt, 8'd0);
`endif
    set_in = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Set press: s after edge 7 only, busy for 5 cycles.
    set_in = 1'b1;
    window("press_set", 14, 7, 0, 7, 11, 1'b0, 0);
    set_in = 1'b0;
    window("rel_set", 10, 0, 0, 0, -1, 1'b0, 0);

    // Clear glitch shorter than the debounce window: nothing issued.
    clr_in = 1'b1;
    repeat (3) tick();
    clr_in = 1'b0;
    window("glitch", 12, 0, 0, 0, -1, 1'b0, 0);

    // Simultaneous presses: clear wins, conflict flagged with r.
    set_in = 1'b1;
    clr_in = 1'b1;
    window("conf", 14, 0, 7, 7, 11, 1'b1, 0);
`ifdef SR_CMD_STATS_EN
    chk("conf_cnt", conflict_cnt, 8'd1);
`endif
    set_in = 1'b0;
    clr_in = 1'b0;
    window("rel_conf", 10, 0, 0, 0, -1, 1'b0, 0);

    // Clear request landing during lockout is dropped.
    set_in = 1'b1;
    window("lock_drop", 16, 7, 0, 7, 11, 1'b0, 3);
    set_in = 1'b0;
    clr_in = 1'b0;
    window("rel_drop", 10, 0, 0, 0, -1, 1'b0, 0);

    // A fresh clear press once idle is issued.
    clr_in = 1'b1;
    window("clr_after", 14, 0, 7, 7, 11, 1'b0, 0);
    clr_in = 1'b0;
    window("rel_clr", 10, 0, 0, 0, -1, 1'b0, 0);

    // Reset during lockout, set held through release.
    set_in = 1'b1;
    window("pre_rst", 9, 7, 0, 7, 9, 1'b0, 0);
    rst = 1'b0;
    #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_s", {7'd0, s}, 8'd0);
    chk("abort_r", {7'd0, r}, 8'd0);
    repeat (2) tick();
    chk("in_rst_busy", {7'd0, busy}, 8'd0);
    tick();
    rst = 1'b1;
    window("post_rst", 12, 7, 0, 7, 11, 1'b0, 0);
    set_in = 1'b0;
    window("rel_post", 10, 0, 0, 0, -1, 1'b0, 0);

`ifdef SR_CMD_STATS_EN
    // Many more conflicts: the counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      set_in = 1'b1;
      clr_in = 1'b1;
      repeat (8) tick();
      set_in = 1'b0;
      clr_in = 1'b0;
      repeat (8) tick();
    end
    chk("sat_cnt", conflict_cnt, 8'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
